// File: rtl/sa_vc_scheduler.sv
// Per-input-port switch-allocation scheduler: round-robin pick of one ready VC,
// per-downstream-VC credit tracking, and downstream VC release on TAIL departure.
module sa_vc_scheduler #(
  parameter  int unsigned VC_NUM      = 2,
  parameter  int unsigned BUFFER_SIZE = 8,
  localparam int unsigned VC_SIZE     = $clog2(VC_NUM),
  localparam int unsigned CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [VC_NUM-1:0]         req_i,
  input  logic [VC_NUM*VC_SIZE-1:0] dvc_i,
  input  logic [VC_NUM-1:0]         is_tail_i,
  input  logic                      out_ready_i,
  input  logic                      credit_valid_i,
  input  logic [VC_SIZE-1:0]        credit_vc_i,
  output logic [VC_NUM-1:0]         grant_o,
  output logic                      grant_valid_o,
  output logic [VC_SIZE-1:0]        grant_vc_o,
  output logic [VC_NUM-1:0]         release_o,
  output logic [VC_NUM*CNT_W-1:0]   credits_o,
  output logic                      err_o
);

  logic [VC_NUM-1:0][CNT_W-1:0] credit_q, credit_d;
  logic [VC_SIZE-1:0]           rr_ptr_q, rr_ptr_d;
  logic                         err_q, err_d;

  logic [VC_NUM-1:0]  elig;
  logic               gnt_found;
  logic [VC_SIZE-1:0] gnt_idx;
  logic [VC_SIZE-1:0] gnt_dvc;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < VC_NUM; i++) begin
      elig[i] = req_i[i] & (credit_q[dvc_i[i*VC_SIZE +: VC_SIZE]] != '0);
    end
  end

  // Scan starts at rr_ptr and wraps; the first eligible VC wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < VC_NUM; k++) begin
      idx = (32'(rr_ptr_q) + k) % VC_NUM;
      if (out_ready_i && !gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = VC_SIZE'(idx);
      end
    end
    gnt_dvc = dvc_i[gnt_idx*VC_SIZE +: VC_SIZE];
  end

  always_comb begin
    grant_o    = '0;
    release_o  = '0;
    grant_vc_o = '0;
    if (gnt_found && !rst) begin
      grant_o[gnt_idx]   = 1'b1;
      release_o[gnt_dvc] = is_tail_i[gnt_idx];
      grant_vc_o         = gnt_idx;
    end
    grant_valid_o = |grant_o;
  end

  // A debit and a return on the same downstream VC cancel out.
  always_comb begin
    logic dec;
    logic inc;
    dec      = 1'b0;
    inc      = 1'b0;
    credit_d = credit_q;
    err_d    = err_q;
    for (int unsigned d = 0; d < VC_NUM; d++) begin
      dec = gnt_found && (gnt_dvc == VC_SIZE'(d));
      inc = credit_valid_i && (credit_vc_i == VC_SIZE'(d));
      if (dec && !inc) begin
        credit_d[d] = credit_q[d] - CNT_W'(1);
      end else if (inc && !dec) begin
        if (credit_q[d] == CNT_W'(BUFFER_SIZE)) begin
          err_d = 1'b1;
        end else begin
          credit_d[d] = credit_q[d] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_found) begin
      rr_ptr_d = (gnt_idx == VC_SIZE'(VC_NUM - 1)) ? '0 : gnt_idx + VC_SIZE'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned d = 0; d < VC_NUM; d++) begin
        credit_q[d] <= CNT_W'(BUFFER_SIZE);
      end
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign credits_o = credit_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_sa_vc_scheduler.sv
// Bench for sa_vc_scheduler: directed scenarios plus random traffic checked
// against a credit/round-robin reference model.
module tb_sa_vc_scheduler;

  localparam int N  = 2;
  localparam int B  = 8;
  localparam int VS = 1;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [N*VS-1:0] dvc_i;
  logic [N-1:0]    is_tail_i;
  logic            out_ready_i;
  logic            credit_valid_i;
  logic [VS-1:0]   credit_vc_i;
  logic [N-1:0]    grant_o;
  logic            grant_valid_o;
  logic [VS-1:0]   grant_vc_o;
  logic [N-1:0]    release_o;
  logic [N*CW-1:0] credits_o;
  logic            err_o;

  sa_vc_scheduler #(.VC_NUM(N), .BUFFER_SIZE(B)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .dvc_i(dvc_i), .is_tail_i(is_tail_i),
    .out_ready_i(out_ready_i), .credit_valid_i(credit_valid_i), .credit_vc_i(credit_vc_i),
    .grant_o(grant_o), .grant_valid_o(grant_valid_o), .grant_vc_o(grant_vc_o),
    .release_o(release_o), .credits_o(credits_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_cred[N];
  int m_ptr;
  bit m_err;

  logic [N-1:0] g_seen;
  logic [N-1:0] rel_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) m_cred[d] = B;
    m_ptr = 0;
    m_err = 0;
  endtask

  // Reset is applied with requests and output ready active to show they are masked.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_i = '1; out_ready_i = 1'b1; dvc_i = 2'b10;
    is_tail_i = '1; credit_valid_i = 1'b0; credit_vc_i = '0;
    #1;
    chk("rst_grant", grant_o, '0);
    chk("rst_grant_valid", grant_valid_o, '0);
    chk("rst_release", release_o, '0);
    chk("rst_credits", credits_o, {4'(B), 4'(B)});
    chk("rst_err", err_o, '0);
    @(negedge clk);
    rst = 1'b0; req_i = '0; is_tail_i = '0;
    model_reset();
  endtask

  task automatic cycle(input logic [N-1:0] req, input logic [N*VS-1:0] dvc,
                       input logic [N-1:0] tail, input logic ordy,
                       input logic cv, input logic [VS-1:0] cvc);
    int eg;
    int ed;
    int i;
    logic [N-1:0] eg_vec;
    logic [N-1:0] erel;
    @(negedge clk);
    req_i = req; dvc_i = dvc; is_tail_i = tail; out_ready_i = ordy;
    credit_valid_i = cv; credit_vc_i = cvc;
    eg = -1; ed = 0;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (eg < 0 && ordy && req[i] && m_cred[dvc[i*VS +: VS]] > 0) eg = i;
    end
    eg_vec = '0; erel = '0;
    if (eg >= 0) begin
      eg_vec[eg] = 1'b1;
      ed = int'(dvc[eg*VS +: VS]);
      if (tail[eg]) erel[ed] = 1'b1;
    end
    #1;
    g_seen = grant_o; rel_seen = release_o;
    chk("grant", grant_o, eg_vec);
    chk("grant_valid", grant_valid_o, 32'(eg >= 0));
    if (eg >= 0) chk("grant_vc", grant_vc_o, eg);
    chk("release", release_o, erel);
    @(posedge clk);
    for (int d = 0; d < N; d++) begin
      bit dec, inc;
      dec = (eg >= 0) && (ed == d);
      inc = cv && (int'(cvc) == d);
      if (dec && !inc) m_cred[d] = m_cred[d] - 1;
      else if (inc && !dec) begin
        if (m_cred[d] == B) m_err = 1;
        else m_cred[d] = m_cred[d] + 1;
      end
    end
    if (eg >= 0) m_ptr = (eg + 1) % N;
    #1;
    for (int d = 0; d < N; d++) chk("credits", credits_o[d*CW +: CW], m_cred[d]);
    chk("err", err_o, 32'(m_err));
  endtask

  initial begin
    rst = 1'b1; req_i = '0; dvc_i = 2'b10; is_tail_i = '0; out_ready_i = 1'b0;
    credit_valid_i = 1'b0; credit_vc_i = '0;
    model_reset();
    do_reset();

    // Alternating grants between two requesters.
    cycle(2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0); chk("t2_g0", g_seen, 2'b01);
    cycle(2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0); chk("t2_g1", g_seen, 2'b10);
    cycle(2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0); chk("t2_g2", g_seen, 2'b01);
    cycle(2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0); chk("t2_g3", g_seen, 2'b10);
    chk("t2_credits", credits_o, {4'd6, 4'd6});

    // Credit exhaustion and recovery.
    do_reset();
    for (int n = 0; n < 8; n++) begin
      cycle(2'b01, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
      chk("t3_grant", g_seen, 2'b01);
    end
    chk("t3_empty", credits_o[CW-1:0], 4'd0);
    cycle(2'b01, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0); chk("t3_starved", g_seen, 2'b00);
    cycle(2'b01, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0); chk("t3_regrant", g_seen, 2'b01);

    // Simultaneous debit and return on one downstream VC.
    do_reset();
    cycle(2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1); chk("t4_grant", g_seen, 2'b01);
    chk("t4_cred1", credits_o[CW +: CW], 4'd8);
    chk("t4_err", err_o, 1'b0);
    cycle(2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0); chk("t4_ptr", g_seen, 2'b10);

    // Overflow sets a sticky error.
    do_reset();
    cycle(2'b00, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("t5_cred0", credits_o[CW-1:0], 4'd8);
    chk("t5_err", err_o, 1'b1);
    for (int n = 0; n < 3; n++) cycle(2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("t5_sticky", err_o, 1'b1);

    // Tail release pulse and out_ready backpressure.
    do_reset();
    cycle(2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0); chk("t6_release", rel_seen, 2'b10);
    cycle(2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0); chk("t6_rel_pulse", rel_seen, 2'b00);
    cycle(2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0); chk("t6_blocked", g_seen, 2'b00);
    cycle(2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0); chk("t6_ptr_held", g_seen, 2'b10);

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      cycle(N'($urandom), ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, N'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, VS'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
